// File: rtl/vram_arbiter_if.sv
// Bundles the three requester ports and the VRAM pin group of the VRAM arbiter.
// The arbiter connects to the slave modport. Requesters and the VRAM model
// connect to the master modport.
interface vram_arbiter_if;
  // video fetch unit
  logic        vidHold;
  logic        vidReq;
  logic [15:0] vidAddr;
  logic [7:0]  vidData;
  logic        vidValid;
  logic        vidLate;
  // CPU bus interface
  logic        cpuReq;
  logic        cpuWe;
  logic [15:0] cpuAddr;
  logic [7:0]  cpuWData;
  logic [7:0]  cpuRData;
  logic        cpuAck;
  // blitter
  logic        bltReq;
  logic        bltWe;
  logic [15:0] bltAddr;
  logic [7:0]  bltWData;
  logic [7:0]  bltRData;
  logic        bltAck;
  // VRAM pins
  logic [14:0] vramAddr;
  logic        nVramCE0;
  logic        nVramCE1;
  logic        nVramRd;
  logic        nVramWr;
  logic [7:0]  vramDout;
  logic        vramDoe;
  logic [7:0]  vramDin;

  modport slave (
    input  vidHold, vidReq, vidAddr,
    output vidData, vidValid, vidLate,
    input  cpuReq, cpuWe, cpuAddr, cpuWData,
    output cpuRData, cpuAck,
    input  bltReq, bltWe, bltAddr, bltWData,
    output bltRData, bltAck,
    output vramAddr, nVramCE0, nVramCE1, nVramRd, nVramWr, vramDout, vramDoe,
    input  vramDin
  );

  modport master (
    output vidHold, vidReq, vidAddr,
    input  vidData, vidValid, vidLate,
    output cpuReq, cpuWe, cpuAddr, cpuWData,
    input  cpuRData, cpuAck,
    output bltReq, bltWe, bltAddr, bltWData,
    input  bltRData, bltAck,
    input  vramAddr, nVramCE0, nVramCE1, nVramRd, nVramWr, vramDout, vramDoe,
    output vramDin
  );
endinterface

// File: rtl/vram_arbiter.sv
// VRAM bus arbiter. It is the only driver of the dual-bank VRAM pins.
// Each slot is one IDLE grant cycle, then ACCESS_CYCLES of STROBE, then one RECOV cycle.
// Video reads win over every other requester. The CPU and the blitter share the
// remaining slots, either round-robin or with fixed CPU priority.
module vram_arbiter #(
  parameter int unsigned ACCESS_CYCLES = 2,  // strobe width, 1..7
  parameter bit          RR_ENABLE     = 1'b1
) (
  input logic           pixClk,
  input logic           reset,
  vram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, STROBE, RECOV} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_VID, OWN_CPU, OWN_BLT} owner_t;

  localparam logic [2:0] LAST_STROBE = 3'(ACCESS_CYCLES - 1);

  state_t      state;
  owner_t      owner;
  logic [2:0]  strobeCnt;
  logic        accWe;
  logic        lastBlt;      // 1 = blitter was served last, so the CPU wins the next tie
  logic        vidPending;
  logic [15:0] vidPendAddr;

  owner_t      grant;
  logic [15:0] grantAddr;
  logic        grantWe;
  logic [7:0]  grantWData;
  logic        cpuWins;

  // Pick the requester that would be granted if the FSM is in IDLE this cycle.
  always_comb begin
    // NOTE: every output gets a default first so that no path leaves one unassigned and infers a latch.
    grant      = OWN_NONE;
    grantAddr  = '0;
    grantWe    = 1'b0;
    grantWData = '0;
    cpuWins    = bus.cpuReq && (!bus.bltReq || !RR_ENABLE || lastBlt);
    if (vidPending) begin
      grant     = OWN_VID;
      grantAddr = vidPendAddr;
    end else if (bus.vidReq) begin
      grant     = OWN_VID;
      grantAddr = bus.vidAddr;
    end else if (!bus.vidHold) begin
      if (cpuWins) begin
        grant      = OWN_CPU;
        grantAddr  = bus.cpuAddr;
        grantWe    = bus.cpuWe;
        grantWData = bus.cpuWData;
      end else if (bus.bltReq) begin
        grant      = OWN_BLT;
        grantAddr  = bus.bltAddr;
        grantWe    = bus.bltWe;
        grantWData = bus.bltWData;
      end
    end
  end

  // Slot sequencer with registered VRAM pins, acks and read data.
  always_ff @(posedge pixClk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register here sees pre-edge values.
    if (reset) begin
      state        <= IDLE;
      owner        <= OWN_NONE;
      strobeCnt    <= '0;
      accWe        <= 1'b0;
      lastBlt      <= 1'b1;
      vidPending   <= 1'b0;
      vidPendAddr  <= '0;
      bus.vramAddr <= '0;
      bus.nVramCE0 <= 1'b1;
      bus.nVramCE1 <= 1'b1;
      bus.nVramRd  <= 1'b1;
      bus.nVramWr  <= 1'b1;
      bus.vramDoe  <= 1'b0;
      bus.vramDout <= '0;
      bus.cpuAck   <= 1'b0;
      bus.bltAck   <= 1'b0;
      bus.vidValid <= 1'b0;
      bus.cpuRData <= '0;
      bus.bltRData <= '0;
      bus.vidData  <= '0;
      bus.vidLate  <= 1'b0;
    end else begin
      bus.cpuAck   <= 1'b0;
      bus.bltAck   <= 1'b0;
      bus.vidValid <= 1'b0;

      // A video request that cannot start now is parked once. A second request is dropped.
      if (bus.vidReq && vidPending) begin
        bus.vidLate <= 1'b1;
      end else if (bus.vidReq && state != IDLE) begin
        vidPending  <= 1'b1;
        vidPendAddr <= bus.vidAddr;
        bus.vidLate <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (grant != OWN_NONE) begin
            state        <= STROBE;
            owner        <= grant;
            strobeCnt    <= '0;
            accWe        <= grantWe;
            bus.vramAddr <= grantAddr[14:0];
            bus.nVramCE0 <= grantAddr[15];
            bus.nVramCE1 <= !grantAddr[15];
            bus.nVramRd  <= grantWe;
            bus.nVramWr  <= !grantWe;
            bus.vramDoe  <= grantWe;
            if (grantWe) bus.vramDout <= grantWData;
            if (grant == OWN_VID) vidPending <= 1'b0;
            if (grant == OWN_CPU) lastBlt <= 1'b0;
            if (grant == OWN_BLT) lastBlt <= 1'b1;
          end
        end
        STROBE: begin
          if (strobeCnt == LAST_STROBE) begin
            state        <= RECOV;
            bus.nVramCE0 <= 1'b1;
            bus.nVramCE1 <= 1'b1;
            bus.nVramRd  <= 1'b1;
            bus.nVramWr  <= 1'b1;
            bus.vramDoe  <= 1'b0;
            case (owner)
              OWN_VID: begin
                bus.vidData  <= bus.vramDin;
                bus.vidValid <= 1'b1;
              end
              OWN_CPU: begin
                if (!accWe) bus.cpuRData <= bus.vramDin;
                bus.cpuAck <= 1'b1;
              end
              OWN_BLT: begin
                if (!accWe) bus.bltRData <= bus.vramDin;
                bus.bltAck <= 1'b1;
              end
              default: ;
            endcase
          end else begin
            strobeCnt <= strobeCnt + 3'd1;
          end
        end
        RECOV: begin
          state <= IDLE;
          owner <= OWN_NONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
